// File: rtl/register_file_dp.sv
// Dual-write, dual-read architectural register file with a pending-write scoreboard.
// Reads are registered and see the same-edge commit; busy flags are combinational.
module register_file_dp #(
    parameter int NREGS   = 32,
    parameter int WIDTH   = 32,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       write,
    input  logic [WIDTH-1:0] wr1,
    input  logic [4:0]       wa1,
    input  logic [WIDTH-1:0] wr2,
    input  logic [4:0]       wa2,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             lock,
    input  logic [4:0]       lock_addr,
    output logic             busy1,
    output logic             busy2
);

    logic [WIDTH-1:0] mem [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [WIDTH-1:0] rd1_next;
    logic [WIDTH-1:0] rd2_next;
    logic             we1;
    logic             we2;
    logic             lock_en;

    function automatic logic in_range(input logic [4:0] a);
        return 32'(a) < NREGS;
    endfunction

    // An address is "live" when it exists and is not the hardwired zero register.
    function automatic logic live(input logic [4:0] a);
        return in_range(a) && !(ZERO_R0 != 0 && a == 5'd0);
    endfunction

    function automatic logic [WIDTH-1:0] read_value(input logic [4:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (live(a)) begin
            if (we2 && wa2 == a)
                v = wr2;
            else if (we1 && wa1 == a)
                v = wr1;
            else
                v = mem[a];
        end
        return v;
    endfunction

    always_comb begin
        we1      = write[0] && live(wa1);
        we2      = write[1] && live(wa2);
        lock_en  = lock && live(lock_addr);
        rd1_next = read_value(ra1);
        rd2_next = read_value(ra2);
    end

    // Port 2 is assigned last so it wins when both ports target one register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= '0;
        end else begin
            if (we1)
                mem[wa1] <= wr1;
            if (we2)
                mem[wa2] <= wr2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            rd1 <= rd1_next;
            rd2 <= rd2_next;
        end
    end

    // Lock is applied after the clears: a fresh producer stays outstanding.
    always_comb begin
        busy_next = busy;
        if (we1)
            busy_next[wa1] = 1'b0;
        if (we2)
            busy_next[wa2] = 1'b0;
        if (lock_en)
            busy_next[lock_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

    always_comb begin
        busy1 = live(ra1) ? busy[ra1] : 1'b0;
        busy2 = live(ra2) ? busy[ra2] : 1'b0;
    end

endmodule

// File: tb/tb_register_file_dp.sv
// Randomized and directed bench for register_file_dp, checking a plain-ZERO_R0
// instance and a ZERO_R0=1 instance side by side against an array model.
module tb_register_file_dp;

    logic        clk;
    logic        rst;
    logic [1:0]  write;
    logic [31:0] wr1;
    logic [4:0]  wa1;
    logic [31:0] wr2;
    logic [4:0]  wa2;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        lock;
    logic [4:0]  lock_addr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy1;
    logic        busy2;
    logic [31:0] rd1_z;
    logic [31:0] rd2_z;
    logic        busy1_z;
    logic        busy2_z;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [32];
    logic        model_busy [32];
    logic [31:0] zmodel_mem [32];
    logic        zmodel_busy [32];

    register_file_dp #(.NREGS(32), .WIDTH(32), .ZERO_R0(0)) dut (
        .clk(clk), .rst(rst), .write(write),
        .wr1(wr1), .wa1(wa1), .wr2(wr2), .wa2(wa2),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .lock(lock), .lock_addr(lock_addr),
        .busy1(busy1), .busy2(busy2)
    );

    register_file_dp #(.NREGS(32), .WIDTH(32), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .write(write),
        .wr1(wr1), .wa1(wa1), .wr2(wr2), .wa2(wa2),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_z), .rd2(rd2_z),
        .lock(lock), .lock_addr(lock_addr),
        .busy1(busy1_z), .busy2(busy2_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Drives one cycle, advances the reference model by the architectural
    // rules (port 1 then port 2 commit, reads see the result, lock after clears)
    // and compares every output of both instances just after the edge.
    task automatic applyStimulus(input logic r, input logic [1:0] w,
                                 input logic [4:0] a1, input logic [31:0] d1,
                                 input logic [4:0] a2, input logic [31:0] d2,
                                 input logic [4:0] r1, input logic [4:0] r2,
                                 input logic lk, input logic [4:0] la);
        logic [31:0] e1, e2, z1, z2;
        @(negedge clk);
        rst = r; write = w; wa1 = a1; wr1 = d1; wa2 = a2; wr2 = d2;
        ra1 = r1; ra2 = r2; lock = lk; lock_addr = la;
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                model_mem[i] = '0; model_busy[i] = 1'b0;
                zmodel_mem[i] = '0; zmodel_busy[i] = 1'b0;
            end
            e1 = '0; e2 = '0; z1 = '0; z2 = '0;
        end else begin
            if (w[0]) begin
                model_mem[a1] = d1; model_busy[a1] = 1'b0;
                if (a1 != 0) begin zmodel_mem[a1] = d1; zmodel_busy[a1] = 1'b0; end
            end
            if (w[1]) begin
                model_mem[a2] = d2; model_busy[a2] = 1'b0;
                if (a2 != 0) begin zmodel_mem[a2] = d2; zmodel_busy[a2] = 1'b0; end
            end
            if (lk) begin
                model_busy[la] = 1'b1;
                if (la != 0) zmodel_busy[la] = 1'b1;
            end
            e1 = model_mem[r1]; e2 = model_mem[r2];
            z1 = zmodel_mem[r1]; z2 = zmodel_mem[r2];
        end
        @(posedge clk);
        #1;
        checkOutput("rd1", rd1, e1);
        checkOutput("rd2", rd2, e2);
        checkOutput("rd1_z", rd1_z, z1);
        checkOutput("rd2_z", rd2_z, z2);
        checkOutput("busy1", 32'(busy1), 32'(model_busy[r1]));
        checkOutput("busy2", 32'(busy2), 32'(model_busy[r2]));
        checkOutput("busy1_z", 32'(busy1_z), 32'(zmodel_busy[r1]));
        checkOutput("busy2_z", 32'(busy2_z), 32'(zmodel_busy[r2]));
    endtask

    // Narrow address range half the time so collisions and bypass hits are common.
    function automatic logic [4:0] randAddr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    task automatic randomCycles(input int n, input int reset_rate);
        for (int k = 0; k < n; k++) begin
            applyStimulus((reset_rate > 0) && ($urandom_range(0, reset_rate - 1) == 0),
                          2'($urandom_range(0, 3)), randAddr(), $urandom(),
                          randAddr(), $urandom(), randAddr(), randAddr(),
                          1'($urandom_range(0, 1)), randAddr());
        end
    endtask

    initial begin
        rst = 1'b1; write = '0; wr1 = '0; wa1 = '0; wr2 = '0; wa2 = '0;
        ra1 = '0; ra2 = '0; lock = 1'b0; lock_addr = '0;

        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        randomCycles(150, 0);

        // Reset after random traffic, then sweep every register and busy bit.
        applyStimulus(1, 2'b11, 3, 32'h55, 4, 32'h66, 3, 4, 1, 3);
        checkOutput("rst_rd1", rd1, 32'h0);
        checkOutput("rst_busy1", 32'(busy1), 32'h0);
        for (int i = 0; i < 32; i++)
            applyStimulus(0, 2'b00, 0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0);

        applyStimulus(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 5, 0, 0, 0);
        checkOutput("single_wr", rd1, 32'hDEADBEEF);

        applyStimulus(0, 2'b11, 7, 32'h1, 7, 32'h2, 0, 0, 0, 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 7, 7, 0, 0);
        checkOutput("collide_r7", rd1, 32'h2);
        applyStimulus(0, 2'b11, 3, 32'h1, 4, 32'h2, 0, 0, 0, 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 3, 4, 0, 0);
        checkOutput("dual_r3", rd1, 32'h1);
        checkOutput("dual_r4", rd2, 32'h2);

        applyStimulus(0, 2'b01, 9, 32'h1234, 0, 0, 9, 9, 0, 0);
        checkOutput("bypass_r9", rd1, 32'h1234);
        applyStimulus(0, 2'b11, 9, 32'hAAAA, 9, 32'hBBBB, 9, 1, 0, 0);
        checkOutput("bypass_p2", rd1, 32'hBBBB);

        applyStimulus(0, 2'b00, 0, 0, 0, 0, 12, 0, 1, 12);
        checkOutput("lock_r12", 32'(busy1), 32'h1);
        applyStimulus(0, 2'b01, 12, 32'h77, 0, 0, 12, 0, 0, 0);
        checkOutput("clear_r12", 32'(busy1), 32'h0);
        applyStimulus(0, 2'b10, 0, 0, 12, 32'h88, 12, 0, 1, 12);
        checkOutput("lock_wins", 32'(busy1), 32'h1);

        applyStimulus(0, 2'b11, 0, 32'h5, 0, 32'h6, 0, 0, 0, 0);
        checkOutput("zero_rd_z", rd1_z, 32'h0);
        checkOutput("zero_rd", rd1, 32'h6);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("zero_busy_z", 32'(busy1_z), 32'h0);
        checkOutput("zero_busy", 32'(busy1), 32'h1);

        randomCycles(300, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
